pll_reset_ctrl: RTL and testbench

Reset and lock supervisor for the 40/160 MHz clock PLL. It runs on the 125 MHz reference clock and drives the PLL's active-high reset. It watches the PLL lock output and releases the system reset only after lock has been continuously stable. On lock timeout it retries the PLL reset, and on lock loss it re-asserts system reset and counts the event for status readout.

---
 rtl/pll_reset_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
//
// Reset and lock supervisor for the 40/160 MHz clock PLL. Runs entirely on
// the 125 MHz reference clock. It pulses the PLL's active-high reset, waits
// for the (synchronized) lock indication, requires lock to be continuously
// stable before releasing the system reset, retries the PLL reset on lock
// timeout and re-asserts system reset when lock is lost while running.
//
// Ports:
//   refclk      in   125 MHz reference clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   raw PLL lock output, asynchronous to refclk
//   reset_req   in   single-cycle request to restart the whole sequence
//   pll_rst     out  active-high reset to the PLL
//   sys_rst_n   out  active-low system reset (high only in RUN)
//   pll_ready   out  high only in RUN
//   lock_fail   out  sticky, set when retry_cnt reaches MAX_RETRIES
//   retry_cnt   out  lock-timeout retries, saturating
//   loss_cnt    out  lock losses seen in RUN, saturating
//   state_dbg   out  0 RESET_HOLD, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//
// Handshake note: there is no valid/ready traffic here. reset_req is a plain
// synchronous strobe, acted on at every refclk edge where it is sampled high;
// it needs no acknowledge and a held-high request simply keeps the block in
// RESET_HOLD with its timer at zero.
// ---------------------------------------------------------------------------
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 125000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             reset_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             pll_ready,
  output logic             lock_fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state_dbg
);

  // -------------------------------------------------------------------------
  // Timer sizing: one shared timer must reach the largest per-state terminal
  // count.
  // -------------------------------------------------------------------------
  localparam int T_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX   = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST     = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT   = '1;
  localparam logic [CNT_W-1:0]   RETRY_LIMIT = CNT_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0]   CNT_SAT     = '1;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_LOCK  = 2'd1,
    STABLE     = 2'd2,
    RUN        = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Lock synchronizer: pll_locked is asynchronous; only locked_s is used.
  // -------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // -------------------------------------------------------------------------
  // State, timer and counter registers
  // -------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               lock_fail_q, lock_fail_d;

  // Decoded strobes from the next-state logic
  logic retry_inc;
  logic loss_inc;
  logic flags_clr;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. reset_req overrides every other condition, including a
  // simultaneous lock drop in RUN (which is then not counted as a loss).
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    flags_clr = 1'b0;

    if (reset_req) begin
      state_d   = RESET_HOLD;
      flags_clr = 1'b1;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          // locked_s deliberately ignored while the PLL is held in reset
          if (timer_q == RST_LAST) begin
            state_d = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (timer_q == TO_LAST) begin
            state_d   = RESET_HOLD;
            retry_inc = 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d  = RESET_HOLD;
            loss_inc = 1'b1;
          end
        end
        default: begin
          state_d = RESET_HOLD;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shared timer: clears on every transition (and on reset_req, which also
  // restarts RESET_HOLD when already there). It saturates so that a long RUN
  // period cannot wrap it.
  // -------------------------------------------------------------------------
  always_comb begin
    timer_d = timer_q;
    if (reset_req || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q != TIMER_SAT) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Retry / loss counters and the sticky lock_fail flag
  // -------------------------------------------------------------------------
  always_comb begin
    retry_d     = retry_q;
    lock_fail_d = lock_fail_q;
    loss_d      = loss_q;

    if (flags_clr) begin
      retry_d     = '0;
      lock_fail_d = 1'b0;
    end else if (retry_inc) begin
      if (retry_q != CNT_SAT) begin
        retry_d = retry_q + 1'b1;
      end
      // Sets on the cycle the count becomes the limit; retrying carries on
      if (retry_d == RETRY_LIMIT) begin
        lock_fail_d = 1'b1;
      end
    end

    // loss_cnt is only cleared by rst_n
    if (loss_inc && (loss_q != CNT_SAT)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs decoded from the next state, so every output moves on
  // the same edge as state_dbg.
  // -------------------------------------------------------------------------
  logic pll_rst_q, sys_rst_n_q, pll_ready_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ready_q <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == RESET_HOLD);
      sys_rst_n_q <= (state_d == RUN);
      pll_ready_q <= (state_d == RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign pll_ready = pll_ready_q;
  assign lock_fail = lock_fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Bench for pll_reset_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=100,
// STABLE_CYCLES=32, MAX_RETRIES=2, CNT_W=8. Inputs are driven on the falling
// edge of refclk, outputs are sampled on the falling edge as well.
// Each vector holds {pll_locked, reset_req, cycles to run, expected outputs};
// the expected output word is queued when the vector is applied and checked
// after the given number of refclk cycles.
// Output word layout: {pll_rst, sys_rst_n, pll_ready, lock_fail,
//                      retry_cnt[7:0], loss_cnt[7:0], state_dbg[1:0]}.
// ---------------------------------------------------------------------------
module tb_pll_reset_ctrl;

  localparam int W = 22;

  // Clock / reset
  logic refclk = 1'b0;
  logic rst_n;
  always #4 refclk = ~refclk;

  // DUT I/O
  logic       pll_locked;
  logic       reset_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       lock_fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [1:0] state_dbg;

  pll_reset_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (32),
    .MAX_RETRIES   (2),
    .CNT_W         (8)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .reset_req  (reset_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state_dbg  (state_dbg)
  );

  logic [W-1:0] obs;
  assign obs = {pll_rst, sys_rst_n, pll_ready, lock_fail, retry_cnt, loss_cnt, state_dbg};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  typedef struct {
    logic         locked;
    logic         req;
    int           cycles;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [W-1:0] mk(input logic pr, input logic sr, input logic rdy,
                                      input logic lf, input logic [7:0] rc,
                                      input logic [7:0] lc, input logic [1:0] st);
    return {pr, sr, rdy, lf, rc, lc, st};
  endfunction

  task automatic add(input logic locked, input logic req, input int cycles, input logic [W-1:0] e);
    vec_t v;
    v.locked = locked;
    v.req    = req;
    v.cycles = cycles;
    v.exp    = e;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic expect_push(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check_pop();
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        n;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: actual empty expected queue, required one pending entry");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = obs;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: actual rst/srst_n/rdy/lf=%b retry=%0d loss=%0d state=%0d, required rst/srst_n/rdy/lf=%b retry=%0d loss=%0d state=%0d",
                 n, a[21:18], a[17:10], a[9:2], a[1:0], e[21:18], e[17:10], e[9:2], e[1:0]);
      end
    end
  endtask

  // Apply inputs, queue the expectation, run the cycles, then compare.
  task automatic run_vec(input string name, input logic locked, input logic req,
                         input int cycles, input logic [W-1:0] e);
    pll_locked = locked;
    reset_req  = req;
    expect_push(name, e);
    for (int c = 0; c < cycles; c++) begin
      tick();
      // reset_req is a single-cycle strobe
      reset_req = 1'b0;
    end
    check_pop();
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    reset_req  = 1'b0;

    // ---------------- vector table ----------------
    // Bring-up
    add(0, 0, 3,  mk(1, 0, 0, 0, 0, 0, 0));  // 0: still in RESET_HOLD after 3 edges
    add(0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 1));  // 1: pll_rst falls on edge 4
    add(0, 0, 9,  mk(0, 0, 0, 0, 0, 0, 1));  // 2: waiting for lock
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 0, 1));  // 3: lock sampled (E0)
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 0, 1));  // 4: E1 locked_s=1
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 0, 2));  // 5: E2 STABLE
    add(1, 0, 31, mk(0, 0, 0, 0, 0, 0, 2));  // 6: E33 still STABLE
    add(1, 0, 1,  mk(0, 1, 1, 0, 0, 0, 3));  // 7: E34 RUN
    add(1, 0, 20, mk(0, 1, 1, 0, 0, 0, 3));  // 8: RUN holds
    // Loss in RUN and re-lock
    add(0, 0, 1,  mk(0, 1, 1, 0, 0, 0, 3));  // 9
    add(0, 0, 1,  mk(0, 1, 1, 0, 0, 0, 3));  // 10
    add(0, 0, 1,  mk(1, 0, 0, 0, 0, 1, 0));  // 11: 2 edges later, loss=1
    add(1, 0, 3,  mk(1, 0, 0, 0, 0, 1, 0));  // 12
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 1));  // 13
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 2));  // 14
    add(1, 0, 31, mk(0, 0, 0, 0, 0, 1, 2));  // 15
    add(1, 0, 1,  mk(0, 1, 1, 0, 0, 1, 3));  // 16: RUN again
    // reset_req in RUN, then glitch in STABLE at cycle 20
    add(1, 1, 1,  mk(1, 0, 0, 0, 0, 1, 0));  // 17
    add(1, 0, 4,  mk(0, 0, 0, 0, 0, 1, 1));  // 18
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 2));  // 19: STABLE entry S
    add(1, 0, 20, mk(0, 0, 0, 0, 0, 1, 2));  // 20: S+20
    add(0, 0, 3,  mk(0, 0, 0, 0, 0, 1, 1));  // 21: 3-cycle drop -> WAIT_LOCK
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 1));  // 22
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 1));  // 23
    add(1, 0, 1,  mk(0, 0, 0, 0, 0, 1, 2));  // 24: STABLE, count restarts
    add(1, 0, 31, mk(0, 0, 0, 0, 0, 1, 2));  // 25: full 32 needed again
    add(1, 0, 1,  mk(0, 1, 1, 0, 0, 1, 3));  // 26
    // Timeout retries
    add(0, 1, 1,  mk(1, 0, 0, 0, 0, 1, 0));  // 27
    add(0, 0, 4,  mk(0, 0, 0, 0, 0, 1, 1));  // 28
    add(0, 0, 99, mk(0, 0, 0, 0, 0, 1, 1));  // 29
    add(0, 0, 1,  mk(1, 0, 0, 0, 1, 1, 0));  // 30: first timeout
    add(0, 0, 4,  mk(0, 0, 0, 0, 1, 1, 1));  // 31
    add(0, 0, 100, mk(1, 0, 0, 1, 2, 1, 0)); // 32: second timeout, lock_fail
    add(0, 0, 4,  mk(0, 0, 0, 1, 2, 1, 1));  // 33
    add(0, 0, 100, mk(1, 0, 0, 1, 3, 1, 0)); // 34: keeps cycling
    add(1, 0, 4,  mk(0, 0, 0, 1, 3, 1, 1));  // 35
    add(1, 0, 1,  mk(0, 0, 0, 1, 3, 1, 2));  // 36
    add(1, 0, 32, mk(0, 1, 1, 1, 3, 1, 3));  // 37
    add(1, 0, 5,  mk(0, 1, 1, 1, 3, 1, 3));  // 38
    // reset_req on the cycle locked_s falls in RUN
    add(0, 0, 1,  mk(0, 1, 1, 1, 3, 1, 3));  // 39
    add(0, 0, 1,  mk(0, 1, 1, 1, 3, 1, 3));  // 40
    add(0, 1, 1,  mk(1, 0, 0, 0, 0, 1, 0));  // 41: loss unchanged, flags cleared
    add(0, 0, 4,  mk(0, 0, 0, 0, 0, 1, 1));  // 42
    add(1, 0, 3,  mk(0, 0, 0, 0, 0, 1, 2));  // 43
    add(1, 0, 10, mk(0, 0, 0, 0, 0, 1, 2));  // 44: mid-STABLE

    // ---------------- reset state ----------------
    repeat (3) @(negedge refclk);
    expect_push("reset_state", mk(1, 0, 0, 0, 0, 0, 0));
    check_pop();
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].locked, tbl[i].req, tbl[i].cycles, tbl[i].exp);
    end

    // ---------------- asynchronous reset during STABLE ----------------
    #2;
    rst_n = 1'b0;
    #1;
    expect_push("async_reset", mk(1, 0, 0, 0, 0, 0, 0));
    check_pop();
    @(negedge refclk);
    rst_n = 1'b1;
    run_vec("rerun_hold",   1, 0, 3,  mk(1, 0, 0, 0, 0, 0, 0));
    run_vec("rerun_wait",   1, 0, 1,  mk(0, 0, 0, 0, 0, 0, 1));
    run_vec("rerun_stable", 1, 0, 1,  mk(0, 0, 0, 0, 0, 0, 2));
    run_vec("rerun_pre",    1, 0, 31, mk(0, 0, 0, 0, 0, 0, 2));
    run_vec("rerun_run",    1, 0, 1,  mk(0, 1, 1, 0, 0, 0, 3));

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
